// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding, default limits and count clamp for the conv sequencer.
package conv_pkg;
    localparam int DEF_MAX_OC_GROUPS = 16;
    localparam int DEF_MAX_TILES     = 64;

    typedef enum logic [3:0] {
        IDLE, LOAD_W, LOAD_B, LOAD_S, LOAD_I, COMPUTE, WAIT, OUTPUT, DONE
    } conv_state_t;

    // Zero is treated as one; anything above the limit saturates.
    function automatic int unsigned clamp_cnt(input int unsigned cnt, input int unsigned max_cnt);
        return (cnt == 0) ? 32'd1 : (cnt > max_cnt) ? max_cnt : cnt;
    endfunction
endpackage

// File: rtl/conv_loop_cnt.sv
// conv_loop_cnt: nested output-channel-group / spatial-tile counter with latched, clamped limits.
module conv_loop_cnt
    import conv_pkg::*;
#(
    parameter int MAX_OC_GROUPS = DEF_MAX_OC_GROUPS,
    parameter int MAX_TILES     = DEF_MAX_TILES,
    parameter int GW            = $clog2(MAX_OC_GROUPS),
    parameter int TW            = $clog2(MAX_TILES)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_latch,
    input  logic          i_clear,
    input  logic          i_inc,
    input  logic [GW:0]   i_cfg_groups,
    input  logic [TW:0]   i_cfg_tiles,
    output logic [GW-1:0] o_oc_idx,
    output logic [TW-1:0] o_tile_idx,
    output logic          o_last_tile,
    output logic          o_last_group
);
    logic [GW:0]   r_groups;
    logic [TW:0]   r_tiles;
    logic [GW-1:0] r_oc;
    logic [TW-1:0] r_tile;

    assign o_oc_idx     = r_oc;
    assign o_tile_idx   = r_tile;
    assign o_last_tile  = ({1'b0, r_tile} == r_tiles - 1'b1);
    assign o_last_group = ({1'b0, r_oc} == r_groups - 1'b1);

    // On the final tile of the final group the indices hold rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_groups <= '0;
            r_tiles  <= '0;
            r_oc     <= '0;
            r_tile   <= '0;
        end else if (i_latch) begin
            r_groups <= (GW+1)'(clamp_cnt(32'(i_cfg_groups), MAX_OC_GROUPS));
            r_tiles  <= (TW+1)'(clamp_cnt(32'(i_cfg_tiles), MAX_TILES));
            r_oc     <= '0;
            r_tile   <= '0;
        end else if (i_clear) begin
            r_oc     <= '0;
            r_tile   <= '0;
        end else if (i_inc) begin
            if (!o_last_tile) begin
                r_tile <= r_tile + 1'b1;
            end else if (!o_last_group) begin
                r_tile <= '0;
                r_oc   <= r_oc + 1'b1;
            end
        end
    end
endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: layer sequencer looping output-channel groups over spatial tiles
// for the 1x1/3x3 conv engines, with start/done handshake and per-resource load flags.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int MAX_OC_GROUPS = DEF_MAX_OC_GROUPS,
    parameter int MAX_TILES     = DEF_MAX_TILES,
    parameter int GW            = $clog2(MAX_OC_GROUPS),
    parameter int TW            = $clog2(MAX_TILES)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [GW:0]   cfg_oc_groups,
    input  logic [TW:0]   cfg_tiles,
    input  logic          cfg_scale_bypass,
    input  logic          cfg_mode_3x3,
    input  logic          weight_load_done,
    input  logic          bias_load_done,
    input  logic          scale_load_done,
    input  logic          input_ready,
    input  logic          calc_valid,
    input  logic          output_done,
    output logic          load_weight_en,
    output logic          read_weight_en,
    output logic          load_bias_en,
    output logic          read_bias_en,
    output logic          load_scale_en,
    output logic          read_scale_en,
    output logic          inputbuf_read_en,
    output logic          conv_en,
    output logic          kernel_mode,
    output logic          output_en,
    output logic [GW-1:0] oc_idx,
    output logic [TW-1:0] tile_idx,
    output logic          busy,
    output logic          done
);
    conv_state_t r_state, w_next;
    logic        r_bypass;
    logic        r_mode;
    logic        w_latch;
    logic        w_abort;
    logic        w_inc;
    logic        w_last_tile;
    logic        w_last_group;

    assign w_latch = (r_state == IDLE) && start;
    assign w_abort = (r_state != IDLE) && abort;
    assign w_inc   = (r_state == OUTPUT) && output_done && !abort;

    conv_loop_cnt #(
        .MAX_OC_GROUPS (MAX_OC_GROUPS),
        .MAX_TILES     (MAX_TILES),
        .GW            (GW),
        .TW            (TW)
    ) u_cnt (
        .clk          (clk),
        .rst          (rst),
        .i_latch      (w_latch),
        .i_clear      (w_abort),
        .i_inc        (w_inc),
        .i_cfg_groups (cfg_oc_groups),
        .i_cfg_tiles  (cfg_tiles),
        .o_oc_idx     (oc_idx),
        .o_tile_idx   (tile_idx),
        .o_last_tile  (w_last_tile),
        .o_last_group (w_last_group)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_bypass <= 1'b0;
            r_mode   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_bypass <= cfg_scale_bypass;
                r_mode   <= cfg_mode_3x3;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? LOAD_W : IDLE;
            LOAD_W:  w_next = weight_load_done ? LOAD_B : LOAD_W;
            LOAD_B:  w_next = !bias_load_done ? LOAD_B : r_bypass ? LOAD_I : LOAD_S;
            LOAD_S:  w_next = scale_load_done ? LOAD_I : LOAD_S;
            LOAD_I:  w_next = input_ready ? COMPUTE : LOAD_I;
            COMPUTE: w_next = WAIT;
            WAIT:    w_next = calc_valid ? OUTPUT : WAIT;
            OUTPUT:  w_next = !output_done ? OUTPUT : !w_last_tile ? LOAD_I :
                              !w_last_group ? LOAD_W : DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        // Abort takes priority over any transition the flags would cause.
        if (w_abort) w_next = IDLE;
    end

    assign load_weight_en   = (r_state == LOAD_W);
    assign read_weight_en   = load_weight_en && weight_load_done;
    assign load_bias_en     = (r_state == LOAD_B);
    assign read_bias_en     = load_bias_en && bias_load_done;
    assign load_scale_en    = (r_state == LOAD_S);
    assign read_scale_en    = load_scale_en && scale_load_done;
    assign inputbuf_read_en = (r_state == LOAD_I);
    assign conv_en          = (r_state == COMPUTE);
    assign output_en        = (r_state == OUTPUT);
    assign done             = (r_state == DONE);
    assign busy             = (r_state != IDLE);
    assign kernel_mode      = r_mode;
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: scoreboard bench; expected (group, tile) per compute pulse is queued at start
// and popped on each conv_en, with per-layer cycle and pulse counts checked against a timing formula.
module tb_conv_seq_ctrl;
    localparam int MAX_OC_GROUPS = 16;
    localparam int MAX_TILES     = 64;
    localparam int GW            = 4;
    localparam int TW            = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [GW:0]   cfg_oc_groups = '0;
    logic [TW:0]   cfg_tiles = '0;
    logic          cfg_scale_bypass = 1'b0;
    logic          cfg_mode_3x3 = 1'b0;
    logic          weight_load_done;
    logic          bias_load_done = 1'b1;
    logic          scale_load_done = 1'b1;
    logic          input_ready = 1'b1;
    logic          calc_valid;
    logic          output_done = 1'b1;
    logic          load_weight_en, read_weight_en, load_bias_en, read_bias_en;
    logic          load_scale_en, read_scale_en, inputbuf_read_en, conv_en;
    logic          kernel_mode, output_en, busy, done;
    logic [GW-1:0] oc_idx;
    logic [TW-1:0] tile_idx;
    logic [21:0]   outs;

    int n_chk = 0, n_pass = 0;
    int wdly = 0, cdly = 0, wc = 0, cc = 0;
    int cyc = 0, base = 0, eg = 1, et = 1;
    int n_conv = 0, n_done = 0, n_lw = 0, n_rw = 0, n_ls = 0;
    int s_conv = 0, s_done = 0, s_lw = 0, s_rw = 0, s_ls = 0;
    int last_done = 0, last_rw = 0, last_conv = 0, last_out = 0;
    logic km_done = 1'b0;
    logic [9:0] q[$];
    logic [9:0] exp_e;

    conv_seq_ctrl #(.MAX_OC_GROUPS(MAX_OC_GROUPS), .MAX_TILES(MAX_TILES)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_oc_groups(cfg_oc_groups), .cfg_tiles(cfg_tiles),
        .cfg_scale_bypass(cfg_scale_bypass), .cfg_mode_3x3(cfg_mode_3x3),
        .weight_load_done(weight_load_done), .bias_load_done(bias_load_done),
        .scale_load_done(scale_load_done), .input_ready(input_ready),
        .calc_valid(calc_valid), .output_done(output_done),
        .load_weight_en(load_weight_en), .read_weight_en(read_weight_en),
        .load_bias_en(load_bias_en), .read_bias_en(read_bias_en),
        .load_scale_en(load_scale_en), .read_scale_en(read_scale_en),
        .inputbuf_read_en(inputbuf_read_en), .conv_en(conv_en),
        .kernel_mode(kernel_mode), .output_en(output_en),
        .oc_idx(oc_idx), .tile_idx(tile_idx), .busy(busy), .done(done)
    );

    assign outs = {load_weight_en, read_weight_en, load_bias_en, read_bias_en, load_scale_en,
                   read_scale_en, inputbuf_read_en, conv_en, kernel_mode, output_en, busy, done,
                   oc_idx, tile_idx};

    // Responders: weight loader finishes wdly cycles late, datapath result cdly cycles late.
    assign weight_load_done = (wc >= wdly);
    assign calc_valid       = (cc >= cdly);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        wc  <= load_weight_en ? wc + 1 : 0;
        cc  <= conv_en ? 0 : (cc < 1000 ? cc + 1 : cc);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (conv_en) begin
            n_conv++;
            last_conv = cyc;
            if (q.size() == 0) chk("conv_extra", 1, 0);
            else begin
                exp_e = q.pop_front();
                chk("conv_idx", {22'd0, oc_idx, tile_idx}, {22'd0, exp_e});
            end
        end
        if (done) begin
            n_done++;
            last_done = cyc;
            km_done = kernel_mode;
        end
        if (load_weight_en) n_lw++;
        if (read_weight_en) begin
            n_rw++;
            last_rw = cyc;
        end
        if (load_scale_en) n_ls++;
        if (output_en) last_out = cyc;
    end

    task automatic start_layer(input int g, input int t, input bit byp, input bit mode,
                               input int wd, input int cd);
        eg = (g == 0) ? 1 : (g > MAX_OC_GROUPS) ? MAX_OC_GROUPS : g;
        et = (t == 0) ? 1 : (t > MAX_TILES) ? MAX_TILES : t;
        @(negedge clk);
        cfg_oc_groups    = (GW+1)'(g);
        cfg_tiles        = (TW+1)'(t);
        cfg_scale_bypass = byp;
        cfg_mode_3x3     = mode;
        wdly = wd;
        cdly = cd;
        for (int o = 0; o < eg; o++)
            for (int k = 0; k < et; k++)
                q.push_back({GW'(o), TW'(k)});
        s_conv = n_conv; s_done = n_done; s_lw = n_lw; s_rw = n_rw; s_ls = n_ls;
        base  = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_layer(input bit byp, input bit mode, input int wd, input int cd);
        int lim = 0;
        while (n_done == s_done && lim < 5000) begin
            @(negedge clk);
            #1;
            lim++;
        end
        chk("done_seen", 32'(n_done != s_done), 1);
        repeat (3) @(negedge clk);
        #1;
        chk("done_cycle", last_done - base, eg * ((byp ? 2 : 3) + wd + et * (4 + cd)) + 1);
        chk("done_pulses", n_done - s_done, 1);
        chk("conv_pulses", n_conv - s_conv, eg * et);
        chk("queue_left", q.size(), 0);
        chk("scale_en_cycles", n_ls - s_ls, byp ? 0 : eg);
        chk("weight_en_cycles", n_lw - s_lw, eg * (1 + wd));
        chk("read_weight_pulses", n_rw - s_rw, eg);
        chk("kernel_mode", 32'(km_done), 32'(mode));
        chk("idle_after", 32'(busy), 0);
    endtask

    initial begin
        int lim;
        #2;
        chk("reset_outputs", 32'(outs), 0);
        @(negedge clk);
        rst = 1'b0;

        start_layer(2, 3, 0, 0, 0, 0);
        finish_layer(0, 0, 0, 0);
        start_layer(2, 3, 1, 1, 0, 0);
        finish_layer(1, 1, 0, 0);
        start_layer(0, 0, 0, 1, 0, 0);
        finish_layer(0, 1, 0, 0);
        start_layer(20, 1, 1, 0, 0, 0);
        finish_layer(1, 0, 0, 0);
        start_layer(1, 100, 1, 1, 0, 0);
        finish_layer(1, 1, 0, 0);

        start_layer(1, 1, 0, 0, 3, 5);
        finish_layer(0, 0, 3, 5);
        chk("read_weight_cycle", last_rw - base, 4);
        chk("wait_dwell", last_out - last_conv, 7);

        start_layer(2, 3, 0, 0, 0, 0);
        lim = 0;
        while (!(conv_en && oc_idx == 1 && tile_idx == 2) && lim < 200) begin
            @(negedge clk);
            #1;
            lim++;
        end
        chk("abort_reach", 32'(lim < 200), 1);
        @(negedge clk);
        abort = 1'b1;
        #1 chk("abort_calc_valid", 32'(calc_valid), 1);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_idle", 32'(busy), 0);
        chk("abort_oc", 32'(oc_idx), 0);
        chk("abort_tile", 32'(tile_idx), 0);
        repeat (4) @(negedge clk);
        #1 chk("abort_no_done", n_done - s_done, 0);
        q.delete();
        start_layer(2, 3, 0, 1, 0, 0);
        finish_layer(0, 1, 0, 0);

        // A start while busy with different config must not disturb the running layer.
        start_layer(2, 2, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        start = 1'b1;
        cfg_oc_groups = 5'd7;
        cfg_mode_3x3  = 1'b1;
        cfg_scale_bypass = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_layer(0, 0, 0, 0);

        start_layer(1, 2, 0, 1, 0, 0);
        lim = 0;
        while (!output_en && lim < 200) begin
            @(negedge clk);
            #1;
            lim++;
        end
        chk("rst_reach_output", 32'(output_en), 1);
        rst = 1'b1;
        #1 chk("rst_outputs", 32'(outs), 0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        #1 chk("rst_stays_idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/conv_seq_ctrl.md
# conv_seq_ctrl

Parametrised sequencer for the convolution engines. It loops a configured number of output-channel groups over a configured number of spatial tiles. For each group it loads weights, bias and an optional scale, then runs load-input / compute / wait / output for every tile. It sits between the layer scheduler (start/done handshake) and the conv datapath and buffer loaders (per-resource done flags). It drives the existing 1x1 and 3x3 engines through a single kernel-mode select.

## Interface
Parameters:
- MAX_OC_GROUPS, 16, maximum output-channel groups per layer
- MAX_TILES, 64, maximum spatial tiles per group
- GW, $clog2(MAX_OC_GROUPS), width of the group index and group count (derived)
- TW, $clog2(MAX_TILES), width of the tile index and tile count (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle layer start request; honoured only in IDLE
- abort  in  1  synchronous abort to IDLE
- cfg_oc_groups  in  GW+1  number of groups; 0 is treated as 1; values above MAX_OC_GROUPS saturate
- cfg_tiles  in  TW+1  number of tiles; 0 is treated as 1; values above MAX_TILES saturate
- cfg_scale_bypass  in  1  1 = skip the LOAD_S state
- cfg_mode_3x3  in  1  kernel select: 0 = 1x1, 1 = 3x3
- weight_load_done, bias_load_done, scale_load_done  in  1 each  loader completion flags
- input_ready  in  1  tile input buffer filled
- calc_valid  in  1  datapath result valid
- output_done  in  1  tile result written out
- load_weight_en, read_weight_en  out  1  weight loader controls
- load_bias_en, read_bias_en  out  1  bias loader controls
- load_scale_en, read_scale_en  out  1  scale loader controls
- inputbuf_read_en  out  1  input buffer fill request
- conv_en  out  1  one-cycle compute trigger
- kernel_mode  out  1  latched cfg_mode_3x3
- output_en  out  1  result output request
- oc_idx  out  GW  current group index
- tile_idx  out  TW  current tile index
- busy  out  1  high in every state other than IDLE
- done  out  1  one-cycle layer-complete pulse

## Operation
- States: IDLE, LOAD_W, LOAD_B, LOAD_S, LOAD_I, COMPUTE, WAIT, OUTPUT, DONE.
- IDLE to LOAD_W on start.
- On the start cycle, latch the clamped cfg_oc_groups, cfg_tiles, cfg_scale_bypass and cfg_mode_3x3, and clear both indices.
- LOAD_W to LOAD_B on weight_load_done.
- LOAD_B: on bias_load_done, go to LOAD_S, or straight to LOAD_I when bypass is latched.
- LOAD_S to LOAD_I on scale_load_done.
- LOAD_I to COMPUTE on input_ready.
- COMPUTE to WAIT unconditionally.
- WAIT to OUTPUT on calc_valid.
- OUTPUT on output_done:
  - not the last tile: tile_idx+1, go to LOAD_I;
  - last tile, not the last group: tile_idx=0, oc_idx+1, go to LOAD_W;
  - last tile of the last group: go to DONE.
- DONE to IDLE unconditionally.
- Output decode is combinational from state:
  - load_X_en=1 throughout its LOAD state;
  - read_X_en=load_X_en & X_load_done;
  - inputbuf_read_en=1 in LOAD_I;
  - conv_en=1 in COMPUTE;
  - output_en=1 in OUTPUT;
  - done=1 in DONE.
- All other outputs are 0 outside those states.
- abort in any non-IDLE state: next state IDLE, indices cleared, no done pulse. abort wins over any simultaneous transition.
- start while busy is ignored. Latched configuration does not change mid-layer.
- The indices are plain counters and never wrap past their latched counts.

## Timing
- Reset: state=IDLE. All outputs 0, including kernel_mode, oc_idx and tile_idx.
- Reset mid-layer returns to IDLE immediately and asynchronously.
- start sampled at edge 0 gives LOAD_W during cycle 1.
- Minimum dwell is one cycle per state, including when a done flag is already high on entry.
- Minimum cycle counts with all flags tied high:
  - per group: 3 cycles of loads (2 with bypass), plus 4 cycles per tile;
  - per layer: groups × that figure, then 1 DONE cycle.
- Index updates take effect on the edge that leaves OUTPUT. They are therefore valid throughout the next LOAD_W or LOAD_I.

## Structure
- Shared package conv_pkg holds:
  - the state enumeration;
  - the default MAX_OC_GROUPS and MAX_TILES constants;
  - the clamp helper function for count inputs.
- One natural sub-module, conv_loop_cnt: a nested group/tile counter with latch, increment, last-flag and clear. The FSM stays in conv_seq_ctrl.

## Test plan
- groups=2, tiles=3, bypass=0, all flags high, start at edge 0 -> done high in cycle 31 only; oc_idx/tile_idx step 0/0 through 1/2; conv_en pulses exactly 6 times.
- Same configuration with bypass=1 -> done in cycle 29; load_scale_en never asserts.
- cfg_tiles=0, cfg_oc_groups=0 -> runs as 1x1: one load sequence and one tile; done in cycle 8.
- calc_valid delayed 5 cycles and weight_load_done delayed 3 cycles -> FSM holds in WAIT/LOAD_W for exactly those cycles; read_weight_en pulses only on the done cycle.
- abort during WAIT of group 1, tile 2 -> IDLE next cycle, indices 0, no done pulse; a new start re-runs from LOAD_W.
- Async rst asserted mid-OUTPUT, and start pulsed while busy -> all outputs 0 immediately on rst; the busy-time start leaves the sequence unchanged.
